seven_seg_scan: RTL

//  Time-multiplexed driver for a DIGITS-digit common-anode/cathode seven-segment display; shows a packed hex word.

---
 rtl/seven_seg_pkg.sv | 22 ++
 rtl/seven_seg_scan_if.sv | 22 ++
 rtl/hex_to_seg.sv | 9 +
 rtl/seven_seg_scan.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low glyph table and index-width helper.
package seven_seg_pkg;

  // Active-low {a,b,c,d,e,f,g}; a = bit 6
  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Minimum of 1 so single-entry counters still get a real bit
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Host-side load bus and display-pin bundle for seven_seg_scan.
interface seven_seg_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] value_in;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic [6:0]          seg_out;
  logic                dp_out;
  logic [DIGITS-1:0]   an_out;
  logic                frame_done;

  modport master (
    output value_in, dp_in, load,
    input  seg_out, dp_out, an_out, frame_done
  );

  modport slave (
    input  value_in, dp_in, load,
    output seg_out, dp_out, an_out, frame_done
  );
endinterface

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = GLYPH[nibble];
endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed hex display driver with frame-synchronous updates and anti-ghost guard.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LZB_EN.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 16,
  parameter int unsigned SEG_ACT_LOW = 1,
  parameter int unsigned AN_ACT_LOW  = 1
) (
  input logic             clk,
  input logic             rst,
  seven_seg_scan_if.slave bus
);

  localparam int unsigned IdxW = clog2(DIGITS);
  localparam int unsigned CntW = clog2(REFRESH_DIV);

  localparam logic [CntW-1:0]   TickMax  = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0]   GuardEnd = CntW'(GUARD);
  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(DIGITS - 1);
  localparam logic [6:0]        SegIdle  = (SEG_ACT_LOW != 0) ? SEG_OFF : 7'h00;
  localparam logic              DpIdle   = (SEG_ACT_LOW != 0);
  localparam logic [DIGITS-1:0] AnIdle   = (AN_ACT_LOW != 0) ? '1 : '0;

  logic [CntW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [IdxW-1:0]     digit_idx_q, digit_idx_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                pend_valid_q, pend_valid_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_done_q, frame_done_d;

  logic                tick, boundary;
  logic [3:0]          nib [DIGITS];
  logic [6:0]          glyph, lit_seg;
  logic [DIGITS-1:0]   an_onehot;

  for (genvar k = 0; k < DIGITS; k++) begin : g_nib
    assign nib[k] = disp_val_q[4*k +: 4];
  end

  hex_to_seg u_hex_to_seg (
    .nibble (nib[digit_idx_q]),
    .seg    (glyph)
  );

`ifdef SEVEN_SEG_LZB_EN
  // A digit blanks when it and every digit above it are zero; digit 0 never blanks
  logic [DIGITS-1:0] blank;
  for (genvar k = 0; k < DIGITS; k++) begin : g_blank
    if (k == 0) begin : g_lsd
      assign blank[k] = 1'b0;
    end else begin : g_upper
      assign blank[k] = ~|disp_val_q[4*DIGITS-1:4*k];
    end
  end
  assign lit_seg = blank[digit_idx_q] ? SEG_OFF : glyph;
`else
  assign lit_seg = glyph;
`endif

  always_comb begin
    tick_cnt_d   = tick_cnt_q + CntW'(1);
    digit_idx_d  = digit_idx_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;

    tick     = (tick_cnt_q == TickMax);
    boundary = tick && (digit_idx_q == LastIdx);

    if (tick) begin
      tick_cnt_d  = '0;
      digit_idx_d = (digit_idx_q == LastIdx) ? '0 : digit_idx_q + IdxW'(1);
    end

    // A load landing on the boundary itself bypasses pend and shows in the new frame
    if (boundary) begin
      pend_valid_d = 1'b0;
      if (bus.load) begin
        disp_val_d = bus.value_in;
        disp_dp_d  = bus.dp_in;
      end else if (pend_valid_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
    end else if (bus.load) begin
      pend_val_d   = bus.value_in;
      pend_dp_d    = bus.dp_in;
      pend_valid_d = 1'b1;
    end

    an_onehot = '0;
    an_onehot[digit_idx_q] = 1'b1;
    if (tick_cnt_q < GuardEnd) an_onehot = '0;

    seg_d        = (SEG_ACT_LOW != 0) ? lit_seg : ~lit_seg;
    dp_d         = (SEG_ACT_LOW != 0) ? ~disp_dp_q[digit_idx_q] : disp_dp_q[digit_idx_q];
    an_d         = (AN_ACT_LOW != 0) ? ~an_onehot : an_onehot;
    frame_done_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q   <= '0;
      digit_idx_q  <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= SegIdle;
      dp_q         <= DpIdle;
      an_q         <= AnIdle;
      frame_done_q <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      digit_idx_q  <= digit_idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.an_out     = an_q;
  assign bus.frame_done = frame_done_q;

endmodule
